// File: rtl/apb_initiator.sv
// rtl/apb_initiator.sv - APB3 requester driven by a valid/ready command channel, with a valid/ready response channel; APB_TIMEOUT_EN adds an ACCESS-phase timeout
module apb_initiator #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    // command channel
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    // response channel
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    // APB3 requester side
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_e;

    state_e              state_q;
    logic                psel_q;
    logic                penable_q;
    logic                pwrite_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic [DATA_W-1:0]   pwdata_q;
    logic                rsp_valid_q;
    logic                rsp_err_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                timeout;

    // A zero timeout would abort before the subordinate could ever answer.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("apb_initiator: TIMEOUT_CYCLES must be at least 1");
    end

`ifdef APB_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    assign timeout = (cnt_q == CNT_LAST);

    // Count wait-state cycles of the current ACCESS phase; restarts for every new transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q != S_ACCESS) begin
            cnt_q <= '0;
        end else if (!pready && !timeout) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Transfer sequencer: IDLE -> SETUP -> ACCESS -> RESP, all APB and response outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Address/data only load on acceptance so the bus stays quiet between transfers.
                    if (cmd_valid) begin
                        pwrite_q <= cmd_write;
                        paddr_q  <= cmd_addr;
                        pwdata_q <= cmd_wdata;
                        psel_q   <= 1'b1;
                        state_q  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (pready) begin
                        // Read data is only meaningful for successful reads.
                        rsp_rdata_q <= (pwrite_q || pslverr) ? '0 : prdata;
                        rsp_err_q   <= pslverr;
                        rsp_valid_q <= 1'b1;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        state_q     <= S_RESP;
                    end else if (timeout) begin
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        state_q     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Ready only in IDLE, and never while reset is held.
    assign cmd_ready = rst_n && (state_q == S_IDLE);

    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_initiator.sv
// tb/tb_apb_initiator.sv - scoreboard bench for apb_initiator
module tb_apb_initiator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          accept_cyc = 0;
    int          w_acc;
    int          hs_cyc;

    int          waits_cfg = 0;
    int          wait_cnt = 0;
    logic [31:0] slv_rdata = '0;
    logic        slv_err = 1'b0;

    logic [32:0] exp_q[$];
    logic [32:0] mon_e;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    apb_initiator #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .psel(psel),
        .penable(penable),
        .pwrite(pwrite),
        .paddr(paddr),
        .pwdata(pwdata),
        .prdata(prdata),
        .pready(pready),
        .pslverr(pslverr)
    );

    // Subordinate model: inserts waits_cfg wait states, drives junk when not ready.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) wait_cnt <= 0;
        else if (psel && penable && !pready) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end
    assign pready  = psel && penable && (wait_cnt >= waits_cfg);
    assign prdata  = pready ? slv_rdata : 32'hA5A5_A5A5;
    assign pslverr = pready ? slv_err : 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor: pops the scoreboard on every response handshake.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_rsp actual=rdata %0h err %0b expected=no response", rsp_rdata, rsp_err);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, mon_e[31:0]);
                chk("rsp_err", rsp_err, mon_e[32]);
            end
        end
    end

    task automatic run_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input int slv_waits, input int n_access,
                            input logic [31:0] rd, input logic err,
                            input logic [31:0] exp_rdata, input logic exp_err);
        int t;
        waits_cfg = slv_waits;
        slv_rdata = rd;
        slv_err   = err;
        exp_q.push_back({exp_err, exp_rdata});
        t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("cmd_accept", cmd_ready, 1);
        accept_cyc = cyc;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("setup_psel_penable", {psel, penable}, 2'b10);
        chk("setup_paddr", paddr, addr);
        chk("setup_pwrite", pwrite, wr);
        chk("setup_pwdata", pwdata, wdata);
        for (int i = 0; i < n_access; i++) begin
            @(negedge clk);
            chk("access_psel_penable_rspv", {psel, penable, rsp_valid}, 3'b110);
            chk("access_paddr", paddr, addr);
        end
        @(negedge clk);
        chk("resp_psel_penable_rspv", {psel, penable, rsp_valid}, 3'b001);
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int slv_waits, input int n_access,
                         input logic [31:0] rd, input logic err,
                         input logic [31:0] exp_rdata, input logic exp_err);
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        run_xfer(wr, addr, wdata, slv_waits, n_access, rd, err, exp_rdata, exp_err);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_apb", {psel, penable, pwrite, paddr, pwdata}, 67'h0);
        chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 34'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_cmd_ready", cmd_ready, 1);

        // write, zero wait states
        issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 1, 32'h1111_1111, 1'b0, 32'h0, 1'b0);
        w_acc = accept_cyc;
        // read with 3 wait states, back to back
        issue(1'b0, 32'h0000_1004, 32'h0, 3, 4, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0);
        chk("b2b_spacing", accept_cyc - w_acc, 4);
        // read with slave error
        issue(1'b0, 32'h0000_1008, 32'h0, 0, 1, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b1);
        // write with slave error and one wait state
        issue(1'b1, 32'h0000_0020, 32'h0000_5A5A, 1, 2, 32'h0, 1'b1, 32'h0, 1'b1);

        // response back-pressure with a new command waiting
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0000_2000;
        cmd_wdata = 32'h0;
        run_xfer(1'b0, 32'h0000_2000, 32'h0, 0, 1, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) begin
                cmd_valid = 1'b1;
                cmd_write = 1'b1;
                cmd_addr  = 32'h0000_2004;
                cmd_wdata = 32'h0000_00C3;
            end
            @(negedge clk);
            chk("hold_cmd_ready", cmd_ready, 0);
            chk("hold_rsp", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 32'h0BAD_F00D});
            chk("hold_psel", psel, 0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        hs_cyc = cyc;
        run_xfer(1'b1, 32'h0000_2004, 32'h0000_00C3, 0, 1, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0);
        chk("hold_next_accept", accept_cyc, hs_cyc + 1);

        // reset in the middle of ACCESS
        @(posedge clk);
        #1;
        waits_cfg = 1000;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0000_3000;
        @(negedge clk);
        chk("rst_mid_accept", cmd_ready, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_in_access", {psel, penable}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_drop", {psel, penable, rsp_valid, cmd_ready}, 4'b0000);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_idle_ready", cmd_ready, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_mid_no_replay", {psel, rsp_valid}, 2'b00);
        end

`ifdef APB_TIMEOUT_EN
        // subordinate never ready: abort after 4 ACCESS cycles
        issue(1'b0, 32'h0000_3008, 32'h0, 1000, 4, 32'h7777_0001, 1'b0, 32'h0, 1'b1);
`else
        // subordinate slow for 100 cycles: requester keeps waiting
        issue(1'b0, 32'h0000_3004, 32'h0, 100, 101, 32'h7777_0001, 1'b0, 32'h7777_0001, 1'b0);
`endif

        // recovery read
        issue(1'b0, 32'h0000_0040, 32'h0, 0, 1, 32'h55AA_55AA, 1'b0, 32'h55AA_55AA, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
